m_cp0: RTL and testbench
========================

Name: m_cp0

Overview:
- Coprocessor 0 for the M stage. Holds SR, Cause, EPC and PRId.
- Arbitrates hardware interrupts against synchronous exceptions that have been carried down the pipe to M.
- Drives `req`, which flushes every pipeline register (including M_W) and redirects the PC to the handler.
- Drives `cp0_out` for mfc0, which M_W latches as M_CP0_out.

Parameters:
- PRID, 32'h2023_B0AA, read-only processor ID value returned at register 15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- we  in  1  mtc0 write enable, from the instruction in M
- addr  in  5  CP0 register number for mtc0/mfc0
- din  in  32  mtc0 write data (forwarded rt value)
- vpc  in  32  PC of the instruction in M (victim PC)
- bd_in  in  1  instruction in M sits in a branch delay slot
- exc_code_in  in  5  accumulated exception code from F/D/E/M; 0 means none
- hw_int  in  6  external interrupt lines: timer0, timer1, interrupt generator, three spare
- eret  in  1  instruction in M is eret
- req  out  1  exception/interrupt taken this cycle (combinational)
- cp0_out  out  32  mfc0 read data (combinational)
- epc_out  out  32  return address for eret (combinational, bypassed)

Behaviour:
- Reset:
  - Asynchronous and active-high; it clears SR, Cause and EPC to 0 immediately.
  - `req` is forced to 0 while reset is high.
  - `cp0_out` and `epc_out` follow the cleared registers.
- SR (reg 12):
  - Implemented bits are IM[15:10], EXL[1] and IE[0]; all other bits read 0.
  - mtc0 writes only the implemented bits.
- Cause (reg 13):
  - Implemented bits are BD[31], IP[15:10] and ExcCode[6:2]; all other bits read 0.
  - Software-read-only; mtc0 to 13 is ignored.
  - IP[15:10] <= hw_int on every clock edge, unconditionally, including the edge on which `req` is taken.
- EPC (reg 14): a full 32-bit register, writable via mtc0.
- PRId (reg 15): returns PRID. Any other `addr` reads 32'h0.
- Request logic, all combinational on the current registers:
  - int_req = IE & ~EXL & |(hw_int & IM).
  - exc_req = ~EXL & (exc_code_in != 0).
  - req = int_req | exc_req.
- Priority: an interrupt beats a synchronous exception in the same cycle.
- On a clock edge with req=1:
  - EXL <= 1.
  - ExcCode <= int_req ? 5'd0 : exc_code_in.
  - BD <= bd_in.
  - EPC <= bd_in ? vpc-4 : vpc, computed in 32-bit wrap-around arithmetic; vpc=0 with bd_in=1 gives 32'hFFFF_FFFC.
- Write rules on a clock edge with req=0:
  - If eret=1, EXL <= 0.
  - If we=1, the register selected by `addr` is written as above.
  - mtc0 to SR/EPC and eret never coincide, because they are distinct instructions.
- Simultaneous events:
  - req=1 suppresses any mtc0 write and any eret in that cycle; the instruction in M is the victim and does not commit.
  - While EXL=1, all requests are masked, including a pending exc_code_in.
- epc_out bypass: epc_out = (we & addr==14) ? din : EPC, so an eret directly after an mtc0 EPC sees the new value.
- cp0_out: read-old semantics. It shows the register value before this cycle's write; there is no self-bypass.
- Latency:
  - `req` is asserted in the same cycle its cause is present.
  - Register updates are visible on the next cycle.
- Reset mid-exception: EXL is cleared and `req` drops immediately; there is no pending state.

Decomposition:
- Shared package holds:
  - CP0 register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12.
  - SR/Cause bit-field positions.
  - Handler entry address 32'h0000_4180, used by the PC logic, not by this block.
- No sub-module is needed. Register file and request logic form a single block of roughly 150–200 lines.

Test Plan:
- Read/write masking:
  - Stimulus: reset; mtc0 SR=32'hFFFF_FFFF; mfc0 12.
  - Required: cp0_out=32'h0000_FC03 on the next cycle; req=0 with hw_int=0.
- Interrupt taken:
  - Stimulus: SR=32'h0000_0401; hw_int=6'b000001; vpc=32'h0000_3010; bd_in=0.
  - Required: req=1 the same cycle. Next cycle: EXL=1, ExcCode=0, EPC=32'h0000_3010, Cause IP[10]=1, req=0.
- Exception in delay slot:
  - Stimulus: EXL=0; exc_code_in=5'd12; bd_in=1; vpc=32'h0000_3024.
  - Required: req=1; then EPC=32'h0000_3020, BD=1, ExcCode=12.
- Priority and masking:
  - Stimulus: interrupt enabled and exc_code_in=5'd10 in the same cycle.
  - Required: ExcCode=0. With EXL=1, the same inputs give req=0.
- eret/mtc0 bypass:
  - Stimulus: mtc0 EPC=32'h0000_3100, then eret the next cycle.
  - Required: epc_out=32'h0000_3100 already during the mtc0 cycle; EXL clears after the eret edge. mtc0 with req=1 leaves EPC unchanged.
- Asynchronous reset:
  - Stimulus: assert reset between clock edges while EXL=1 and hw_int=6'h3F.
  - Required: req=0 and SR/Cause/EPC read 0 before the next edge.

Source files
------------

// File: rtl/m_cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and bit-field
// positions of SR and Cause, plus the handler entry used by the PC logic.
package m_cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Exception codes carried down the pipe
  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  // SR field positions
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;

  // Cause field positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // Exception handler entry point (consumed by the PC logic)
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/m_cp0_if.sv
// Bus between the M stage and CP0: mtc0/mfc0 access, victim info,
// interrupt lines, and the request/read-back outputs.
interface m_cp0_if;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] cp0_out;
  logic [31:0] epc_out;

  // Pipeline side: drives the instruction info, receives request/read data
  modport master (
    output we, addr, din, vpc, bd_in, exc_code_in, hw_int, eret,
    input  req, cp0_out, epc_out
  );

  // CP0 side
  modport slave (
    input  we, addr, din, vpc, bd_in, exc_code_in, hw_int, eret,
    output req, cp0_out, epc_out
  );
endinterface

// File: rtl/m_cp0.sv
// Coprocessor 0 in the M stage: SR/Cause/EPC/PRId register file,
// interrupt/exception arbitration, and mfc0/eret read paths.
module m_cp0
  import m_cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2023_B0AA
) (
  input  logic     clk,
  input  logic     reset,
  m_cp0_if.slave   bus
);

  logic [5:0]  im_q,  im_d;
  logic        exl_q, exl_d;
  logic        ie_q,  ie_d;
  logic        bd_q,  bd_d;
  logic [5:0]  ip_q,  ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] rd_val;

  // Request arbitration; reset masks req because exc_code_in is not a register
  always_comb begin
    int_req = ie_q & ~exl_q & (|(bus.hw_int & im_q));
    exc_req = ~exl_q & (bus.exc_code_in != 5'd0);
    req     = (int_req | exc_req) & ~reset;
  end

  // Next-state: exception entry dominates; otherwise eret and mtc0 commit
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = bus.hw_int;
    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : bus.exc_code_in;
      bd_d       = bus.bd_in;
      epc_d      = bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
    end else begin
      if (bus.eret) begin
        exl_d = 1'b0;
      end
      if (bus.we) begin
        case (bus.addr)
          CP0_SR: begin
            im_d  = bus.din[SR_IM_HI:SR_IM_LO];
            exl_d = bus.din[SR_EXL];
            ie_d  = bus.din[SR_IE];
          end
          CP0_EPC: epc_d = bus.din;
          default: ;
        endcase
      end
    end
  end

  // Register state with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // mfc0 read mux (old register values, no write bypass)
  always_comb begin
    sr_val                          = '0;
    sr_val[SR_IM_HI:SR_IM_LO]       = im_q;
    sr_val[SR_EXL]                  = exl_q;
    sr_val[SR_IE]                   = ie_q;
    cause_val                       = '0;
    cause_val[CAUSE_BD]             = bd_q;
    cause_val[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
    cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_q;
    case (bus.addr)
      CP0_SR:    rd_val = sr_val;
      CP0_CAUSE: rd_val = cause_val;
      CP0_EPC:   rd_val = epc_q;
      CP0_PRID:  rd_val = PRID;
      default:   rd_val = '0;
    endcase
  end

  // Outputs; epc_out bypasses an mtc0 EPC so a following eret sees it
  always_comb begin
    bus.req     = req;
    bus.cp0_out = rd_val;
    bus.epc_out = (bus.we && (bus.addr == CP0_EPC)) ? bus.din : epc_q;
  end

endmodule

// File: tb/tb_m_cp0.sv
// Directed testbench for m_cp0: inputs change on the falling edge,
// combinational outputs and register reads are sampled before the next rise.
module tb_m_cp0;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] v;

  m_cp0_if bus ();

  m_cp0 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #90000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.we          = 1'b0;
    bus.addr        = 5'd0;
    bus.din         = 32'h0;
    bus.vpc         = 32'h0;
    bus.bd_in       = 1'b0;
    bus.exc_code_in = 5'd0;
    bus.hw_int      = 6'd0;
    bus.eret        = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] val);
    bus.addr = a;
    #1;
    val = bus.cp0_out;
  endtask

  // one cycle of mtc0 starting at a falling edge
  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1; bus.addr = a; bus.din = d;
    @(posedge clk);
    @(negedge clk);
    bus.we = 1'b0; bus.din = 32'h0;
  endtask

  task automatic do_eret();
    @(negedge clk);
    bus.eret = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.eret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.exc_code_in = 5'd4;
    #3;
    checks++;
    if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.req); end
    bus.exc_code_in = 5'd0;
    rd(5'd12, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_sr: got %h expected 00000000", v); end
    rd(5'd13, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h expected 00000000", v); end
    rd(5'd14, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected 00000000", v); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sr_mask();
    @(negedge clk);
    bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'hFFFF_FFFF;
    #1; checks++;
    if (bus.req !== 1'b0) begin errors++; $display("FAIL mask_req: got %b expected 0", bus.req); end
    @(posedge clk);
    @(negedge clk);
    bus.we = 1'b0;
    rd(5'd12, v); checks++;
    if (v !== 32'h0000_FC03) begin errors++; $display("FAIL sr_mask: got %h expected 0000fc03", v); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL cause_ro: got %h expected 00000000", v); end
    rd(5'd15, v); checks++;
    if (v !== 32'h2023_B0AA) begin errors++; $display("FAIL prid: got %h expected 2023b0aa", v); end
    rd(5'd3, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL unimpl_reg: got %h expected 00000000", v); end
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, v); checks++;
    if (v !== 32'h0000_0401) begin errors++; $display("FAIL sr_write: got %h expected 00000401", v); end
  endtask

  task automatic test_interrupt();
    @(negedge clk);
    bus.hw_int = 6'b000001; bus.vpc = 32'h0000_3010; bus.bd_in = 1'b0;
    #1; checks++;
    if (bus.req !== 1'b1) begin errors++; $display("FAIL int_req: got %b expected 1", bus.req); end
    @(posedge clk);
    @(negedge clk);
    #1; checks++;
    if (bus.req !== 1'b0) begin errors++; $display("FAIL int_exl_mask: got %b expected 0", bus.req); end
    rd(5'd12, v); checks++;
    if (v !== 32'h0000_0403) begin errors++; $display("FAIL int_sr: got %h expected 00000403", v); end
    rd(5'd13, v); checks++;
    if (v !== 32'h0000_0400) begin errors++; $display("FAIL int_cause: got %h expected 00000400", v); end
    rd(5'd14, v); checks++;
    if (v !== 32'h0000_3010) begin errors++; $display("FAIL int_epc: got %h expected 00003010", v); end
    bus.hw_int = 6'd0;
  endtask

  task automatic test_delay_slot_exc();
    do_eret();
    rd(5'd12, v); checks++;
    if (v !== 32'h0000_0401) begin errors++; $display("FAIL eret_clear: got %h expected 00000401", v); end
    bus.exc_code_in = 5'd12; bus.bd_in = 1'b1; bus.vpc = 32'h0000_3024;
    #1; checks++;
    if (bus.req !== 1'b1) begin errors++; $display("FAIL ds_req: got %b expected 1", bus.req); end
    @(posedge clk);
    @(negedge clk);
    idle();
    rd(5'd14, v); checks++;
    if (v !== 32'h0000_3020) begin errors++; $display("FAIL ds_epc: got %h expected 00003020", v); end
    rd(5'd13, v); checks++;
    if (v !== 32'h8000_0030) begin errors++; $display("FAIL ds_cause: got %h expected 80000030", v); end
  endtask

  task automatic test_priority();
    do_eret();
    bus.hw_int = 6'b000001; bus.exc_code_in = 5'd10; bus.vpc = 32'h0000_3040;
    #1; checks++;
    if (bus.req !== 1'b1) begin errors++; $display("FAIL prio_req: got %b expected 1", bus.req); end
    @(posedge clk);
    @(negedge clk);
    #1; checks++;
    if (bus.req !== 1'b0) begin errors++; $display("FAIL prio_masked: got %b expected 0", bus.req); end
    bus.vpc = 32'h0000_5000;
    rd(5'd13, v); checks++;
    if (v !== 32'h0000_0400) begin errors++; $display("FAIL prio_cause: got %h expected 00000400", v); end
    @(posedge clk);
    @(negedge clk);
    rd(5'd14, v); checks++;
    if (v !== 32'h0000_3040) begin errors++; $display("FAIL prio_epc_hold: got %h expected 00003040", v); end
    idle();
  endtask

  task automatic test_epc_wrap();
    do_eret();
    bus.exc_code_in = 5'd4; bus.bd_in = 1'b1; bus.vpc = 32'h0;
    #1; checks++;
    if (bus.req !== 1'b1) begin errors++; $display("FAIL wrap_req: got %b expected 1", bus.req); end
    @(posedge clk);
    @(negedge clk);
    idle();
    rd(5'd14, v); checks++;
    if (v !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_epc: got %h expected fffffffc", v); end
    rd(5'd13, v); checks++;
    if (v !== 32'h8000_0010) begin errors++; $display("FAIL wrap_cause: got %h expected 80000010", v); end
  endtask

  task automatic test_eret_bypass();
    @(negedge clk);
    bus.we = 1'b1; bus.addr = 5'd14; bus.din = 32'h0000_3100;
    #1; checks++;
    if (bus.epc_out !== 32'h0000_3100) begin errors++; $display("FAIL bypass_epc_out: got %h expected 00003100", bus.epc_out); end
    checks++;
    if (bus.cp0_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL read_old: got %h expected fffffffc", bus.cp0_out); end
    @(posedge clk);
    @(negedge clk);
    bus.we = 1'b0; bus.din = 32'h0; bus.addr = 5'd0; bus.eret = 1'b1;
    #1; checks++;
    if (bus.epc_out !== 32'h0000_3100) begin errors++; $display("FAIL eret_epc_out: got %h expected 00003100", bus.epc_out); end
    @(posedge clk);
    @(negedge clk);
    bus.eret = 1'b0;
    rd(5'd12, v); checks++;
    if (v !== 32'h0000_0401) begin errors++; $display("FAIL eret_exl: got %h expected 00000401", v); end
    bus.we = 1'b1; bus.addr = 5'd14; bus.din = 32'hDEAD_BEEF;
    bus.hw_int = 6'b000001; bus.vpc = 32'h0000_3200; bus.bd_in = 1'b0;
    #1; checks++;
    if (bus.req !== 1'b1) begin errors++; $display("FAIL suppress_req: got %b expected 1", bus.req); end
    @(posedge clk);
    @(negedge clk);
    idle();
    rd(5'd14, v); checks++;
    if (v !== 32'h0000_3200) begin errors++; $display("FAIL suppress_mtc0: got %h expected 00003200", v); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.hw_int = 6'h3F; bus.exc_code_in = 5'd8;
    #2;
    reset = 1'b1;
    #1; checks++;
    if (bus.req !== 1'b0) begin errors++; $display("FAIL areset_req: got %b expected 0", bus.req); end
    rd(5'd12, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL areset_sr: got %h expected 00000000", v); end
    rd(5'd13, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL areset_cause: got %h expected 00000000", v); end
    rd(5'd14, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL areset_epc: got %h expected 00000000", v); end
    @(negedge clk);
    idle();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sr_mask();
    test_interrupt();
    test_delay_slot_exc();
    test_priority();
    test_epc_wrap();
    test_eret_bypass();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
